// File: rtl/fp_threshold_act_if.sv
// Handshake, data and configuration bundle for fp_threshold_act.
// The master drives input beats, config and out_ready; the slave is the unit.
interface fp_threshold_act_if #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
);
  logic                  cfg_we;
  logic [31:0]           cfg_thresh;
  logic [1:0]            cfg_mode;
  logic                  in_valid;
  logic                  in_ready;
  logic [32*LANES-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [32*LANES-1:0]   out_data;
  logic [LANES-1:0]      out_nan;
  logic [CNT_W-1:0]      nan_cnt;
  logic                  clr_cnt;

  modport master (
    output cfg_we, cfg_thresh, cfg_mode, in_valid, in_data, out_ready, clr_cnt,
    input  in_ready, out_valid, out_data, out_nan, nan_cnt
  );

  modport slave (
    input  cfg_we, cfg_thresh, cfg_mode, in_valid, in_data, out_ready, clr_cnt,
    output in_ready, out_valid, out_data, out_nan, nan_cnt
  );
endinterface

// File: rtl/fp_threshold_act.sv
// Two-stage multi-lane IEEE-754 single threshold activation (step/ReLU/bypass)
// with valid/ready flow control and a saturating NaN-lane counter.
module fp_threshold_act #(
  parameter int          LANES      = 4,
  parameter logic [31:0] THRESH_RST = 32'h3E80_0006,
  parameter logic [1:0]  MODE_RST   = 2'b00,
  parameter int          CNT_W      = 16
) (
  input logic              clk,
  input logic              rst_n,
  fp_threshold_act_if.slave bus
);

  localparam logic [1:0]  MODE_STEP_LT = 2'b00;
  localparam logic [1:0]  MODE_STEP_GE = 2'b01;
  localparam logic [1:0]  MODE_RELU_T  = 2'b10;
  localparam logic [1:0]  MODE_BYPASS  = 2'b11;
  localparam logic [31:0] FP_ONE       = 32'h3F80_0000;

  logic [31:0]         r_thresh;
  logic [1:0]          r_mode;
  logic [CNT_W-1:0]    r_nan_cnt;

  logic                r_s1_v;
  logic [32*LANES-1:0] r_s1_data;
  logic [1:0]          r_s1_mode;
  logic [LANES-1:0]    r_s1_lt;
  logic [LANES-1:0]    r_s1_eq;
  logic [LANES-1:0]    r_s1_nan;

  logic                r_s2_v;
  logic [32*LANES-1:0] r_out_data;
  logic [LANES-1:0]    r_out_nan;

  logic                w_s2_adv;
  logic                w_s1_adv;
  logic                w_accept;
  logic [LANES-1:0]    w_lt;
  logic [LANES-1:0]    w_eq;
  logic [LANES-1:0]    w_nan;
  logic [CNT_W:0]      w_pop;
  logic [CNT_W:0]      w_cnt_sum;
  logic [32*LANES-1:0] w_res;

  // Sign-magnitude ordering: magnitudes compare directly, reversed when both negative.
  function automatic logic f_lt(input logic [31:0] x, input logic [31:0] t);
    if ((x[30:0] == '0) && (t[30:0] == '0)) return 1'b0;
    if (x[31] != t[31])                     return x[31];
    if (x[31])                              return x[30:0] > t[30:0];
    return x[30:0] < t[30:0];
  endfunction

  function automatic logic f_eq(input logic [31:0] x, input logic [31:0] t);
    return (x == t) || ((x[30:0] == '0) && (t[30:0] == '0));
  endfunction

  assign w_s2_adv     = !r_s2_v || bus.out_ready;
  assign w_s1_adv     = !r_s1_v || w_s2_adv;
  assign w_accept     = bus.in_valid && w_s1_adv;

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_s2_v;
  assign bus.out_data  = r_out_data;
  assign bus.out_nan   = r_out_nan;
  assign bus.nan_cnt   = r_nan_cnt;

  always_comb begin
    w_lt  = '0;
    w_eq  = '0;
    w_nan = '0;
    w_pop = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_lt[i]  = f_lt(bus.in_data[32*i +: 32], r_thresh);
      w_eq[i]  = f_eq(bus.in_data[32*i +: 32], r_thresh);
      w_nan[i] = (bus.in_data[32*i+30 -: 8] == 8'hFF) && (bus.in_data[32*i +: 23] != '0);
      w_pop    = w_pop + (CNT_W+1)'(w_nan[i]);
    end
  end

  assign w_cnt_sum = {1'b0, r_nan_cnt} + w_pop;

  always_comb begin
    w_res = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      logic [31:0] x;
      logic        ge;
      x  = r_s1_data[32*i +: 32];
      ge = !r_s1_lt[i] || r_s1_eq[i];
      if (r_s1_nan[i]) begin
        w_res[32*i +: 32] = (r_s1_mode == MODE_BYPASS) ? x : '0;
      end else begin
        unique case (r_s1_mode)
          MODE_STEP_LT: w_res[32*i +: 32] = ge ? '0 : FP_ONE;
          MODE_STEP_GE: w_res[32*i +: 32] = ge ? FP_ONE : '0;
          MODE_RELU_T:  w_res[32*i +: 32] = ge ? x : '0;
          default:      w_res[32*i +: 32] = x;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thresh <= THRESH_RST;
      r_mode   <= MODE_RST;
    end else if (bus.cfg_we) begin
      r_thresh <= bus.cfg_thresh;
      r_mode   <= bus.cfg_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nan_cnt <= '0;
    end else if (bus.clr_cnt) begin
      r_nan_cnt <= '0;
    end else if (w_accept) begin
      r_nan_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
    end
  end

  // Stage 1 snapshots the pre-write config so a same-cycle cfg_we only affects later beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
      r_s1_mode <= '0;
      r_s1_lt   <= '0;
      r_s1_eq   <= '0;
      r_s1_nan  <= '0;
    end else if (w_s1_adv) begin
      r_s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_data <= bus.in_data;
        r_s1_mode <= r_mode;
        r_s1_lt   <= w_lt;
        r_s1_eq   <= w_eq;
        r_s1_nan  <= w_nan;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v     <= 1'b0;
      r_out_data <= '0;
      r_out_nan  <= '0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_out_data <= w_res;
        r_out_nan  <= r_s1_nan;
      end
    end
  end

endmodule

// File: doc/fp_threshold_act.md
# fp_threshold_act

Pipelined, multi-lane IEEE-754 single-precision threshold activation unit for the systolic array output path. Each accepted beat carries LANES floats; each lane is compared against a runtime-programmable threshold and mapped according to a runtime-selectable mode (step-below, step-at-or-above, thresholded ReLU, bypass). Sits between the accumulator drain and the next layer's operand buffer with valid/ready flow control on both sides. NaN inputs are flagged per lane and counted.

## Interface
- LANES, 4, number of 32-bit lanes per beat (1..16)
- THRESH_RST, 32'h3E80_0006, threshold value after reset
- MODE_RST, 2'b00, mode after reset
- CNT_W, 16, width of the saturating NaN counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  load cfg_thresh/cfg_mode this cycle
- cfg_thresh  in  32  new threshold (IEEE-754 single)
- cfg_mode  in  2  new mode: 00 STEP_LT, 01 STEP_GE, 10 RELU_T, 11 BYPASS
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat
- in_data  in  32*LANES  lane i at bits [32i+31:32i]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  32*LANES  result per lane
- out_nan  out  LANES  lane i input was NaN
- nan_cnt  out  CNT_W  saturating count of NaN lanes accepted
- clr_cnt  in  1  synchronous clear of nan_cnt

## Operation
- Config registers thresh_q/mode_q load on cfg_we; reset to THRESH_RST/MODE_RST.
- A beat accepted (in_valid & in_ready) snapshots thresh_q/mode_q as they stand before any same-cycle cfg_we; the snapshot travels with the beat. A write affects only beats accepted on later cycles.
- Compare is a direct sign-magnitude compare, no adder: x<T decided by sign bits then magnitude (reversed for negatives). +0 and -0 compare equal. Denormals compared as ordinary magnitudes. Infinities ordered normally.
- NaN (exp=FF, mant≠0) in a lane: lane output 32'h0000_0000 in every mode including BYPASS? No: BYPASS passes NaN unchanged; all other modes output 0. out_nan[i] set in all modes.
- STEP_LT: out = 32'h3F80_0000 if x<T else 0. STEP_GE: out = 1.0 if x≥T else 0. RELU_T: out = x if x≥T else 0. BYPASS: out = x.
- nan_cnt adds popcount(NaN lanes) per accepted beat, saturates at all-ones; clr_cnt has priority over increment in the same cycle.

## Timing
- Two-stage pipeline. S1 registers lane data, config snapshot and per-lane lt/eq/nan flags. S2 registers final out_data/out_nan. Latency: beat accepted in cycle n is out_valid in cycle n+2 if not stalled.
- Stage advances when it is empty or the stage after it is empty or consuming. in_ready = !s1_v | !s2_v | out_ready (combinational from out_ready only).
- Full throughput 1 beat/cycle with out_ready held high. out_ready low holds out_data/out_nan stable; at most 2 beats buffered; no beat lost or duplicated.
- out_valid may rise without out_ready; once raised it stays until taken.
- nan_cnt updates the cycle after acceptance (counted at S1 entry).
- Reset (any time, mid-stream): s1/s2 valid=0, out_valid=0, out_data=0, out_nan=0, nan_cnt=0, thresh_q=THRESH_RST, mode_q=MODE_RST; in-flight beats discarded. in_ready=1 during and after reset.

## Test plan
- Reset defaults, STEP_LT, LANES=4: lanes {0x00000000, 0x3F800000, 0xC0000000, 0x3E800006} -> {0x3F800000, 0x0, 0x3F800000, 0x0}, out_valid exactly 2 cycles after accept.
- cfg thresh=0x00000000 mode=STEP_GE: lanes {0x80000000, 0xBF800000, 0x7F800000, 0x00000001} -> {0x3F800000, 0x0, 0x3F800000, 0x3F800000}; same with RELU_T -> {0x80000000, 0x0, 0x7F800000, 0x00000001}.
- NaN: lane0 0x7FC00000 in STEP_LT -> out 0, out_nan=4'b0001, nan_cnt 0->1; BYPASS -> out 0x7FC00000; clr_cnt with simultaneous NaN beat -> nan_cnt=0.
- Backpressure: stream 6 beats with out_ready low cycles 3-5: in_ready drops after 2 buffered beats, outputs in order, held stable, none lost/duplicated.
- cfg_we to RELU_T in the same cycle as beat k accept: beat k uses STEP_LT, beat k+1 uses RELU_T.
- Assert rst_n low with 2 beats in flight: out_valid=0 immediately (async), no stale beat after release, nan_cnt=0.
